// File: rtl/setup_responder.sv
// rtl/setup_responder.sv - stand-in for the physical setup answering the experiment sequencer
//
// Purpose:
//   Cycle-accurate responder that replaces the real setup in the FPGA test build
//   and the simulation bench. It reacts to the sequencer's start, detonation and
//   trigger outputs with fg_signal, wire_signal and detector_ready, and offers
//   fault inputs to drive the sequencer into its wait and timeout paths.
//
// Ports:
//   clock                 in   system clock, all logic on its rising edge
//   reset_n               in   asynchronous active-low reset
//   enable                in   responder active; low forces IDLE synchronously
//   start_signal          in   rising edge starts a shot (IDLE only)
//   detonation_signal     in   rising edge accepted only in ARMED
//   output_trigger        in   rising edge accepted only in TRIG_WAIT
//   fault_no_wire         in   sampled on ARMED->WIRE_DELAY; 1 suppresses the wire pulse
//   fault_detector_stuck  in   sampled on TRIG_WAIT->DET_BUSY; 1 keeps detector_ready low
//   fg_signal             out  FG charged, high in ARMED
//   wire_signal           out  wire break pulse, high in WIRE_PULSE
//   detector_ready        out  detector done, high in DET_READY
//   busy                  out  state is not IDLE
//   shot_count            out  completed shots, wraps 0xFFFF -> 0
//   error                 out  sticky protocol error, cleared by an accepted start

module setup_responder #(
  parameter int unsigned FG_CHARGE_CYCLES     = 1000,
  parameter int unsigned WIRE_DELAY_CYCLES    = 200,
  parameter int unsigned WIRE_PULSE_CYCLES    = 4,
  parameter int unsigned DETECTOR_BUSY_CYCLES = 3,
  parameter int unsigned CNT_W                = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        start_signal,
  input  logic        detonation_signal,
  input  logic        output_trigger,
  input  logic        fault_no_wire,
  input  logic        fault_detector_stuck,
  output logic        fg_signal,
  output logic        wire_signal,
  output logic        detector_ready,
  output logic        busy,
  output logic [15:0] shot_count,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_CHARGE     = 3'd1,
    S_ARMED      = 3'd2,
    S_WIRE_DELAY = 3'd3,
    S_WIRE_PULSE = 3'd4,
    S_TRIG_WAIT  = 3'd5,
    S_DET_BUSY   = 3'd6,
    S_DET_READY  = 3'd7
  } state_e;

  // Terminal counts: a phase of N cycles ends when the counter reads N-1.
  localparam logic [CNT_W-1:0] FG_LAST = CNT_W'(FG_CHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WIRE_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] WP_LAST = CNT_W'(WIRE_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DETECTOR_BUSY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             no_wire_q, no_wire_d;
  logic             stuck_q, stuck_d;
  logic             error_q, error_d;
  logic [15:0]      shot_count_q, shot_count_d;

  logic             start_q, det_q, trig_q;
  logic             start_rise, det_rise, trig_rise;

  logic             fg_q, fg_d;
  logic             wire_q, wire_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic             err_set, err_clr;

  assign start_rise = start_signal & ~start_q;
  assign det_rise   = detonation_signal & ~det_q;
  assign trig_rise  = output_trigger & ~trig_q;

  // State register and all other registered state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      no_wire_q    <= 1'b0;
      stuck_q      <= 1'b0;
      error_q      <= 1'b0;
      shot_count_q <= 16'h0000;
      start_q      <= 1'b0;
      det_q        <= 1'b0;
      trig_q       <= 1'b0;
      fg_q         <= 1'b0;
      wire_q       <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      no_wire_q    <= no_wire_d;
      stuck_q      <= stuck_d;
      error_q      <= error_d;
      shot_count_q <= shot_count_d;
      start_q      <= start_signal;
      det_q        <= detonation_signal;
      trig_q       <= output_trigger;
      fg_q         <= fg_d;
      wire_q       <= wire_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic. Every input edge is judged against the current state,
  // even when the state changes on the same clock.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    no_wire_d    = no_wire_q;
    stuck_d      = stuck_q;
    error_d      = error_q;
    shot_count_d = shot_count_q;
    err_set      = 1'b0;
    err_clr      = 1'b0;

    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      if (det_rise && state_q != S_ARMED) begin
        err_set = 1'b1;
      end
      if (trig_rise && state_q != S_TRIG_WAIT && state_q != S_DET_BUSY &&
          state_q != S_DET_READY) begin
        err_set = 1'b1;
      end
      if (start_rise && state_q != S_IDLE) begin
        err_set = 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (start_rise) begin
            state_d = S_CHARGE;
            cnt_d   = '0;
            err_clr = 1'b1;
          end
        end
        S_CHARGE: begin
          if (cnt_q == FG_LAST) begin
            state_d = S_ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_ARMED: begin
          if (det_rise) begin
            state_d   = S_WIRE_DELAY;
            cnt_d     = '0;
            no_wire_d = fault_no_wire;
          end
        end
        S_WIRE_DELAY: begin
          if (cnt_q == WD_LAST) begin
            // A suppressed wire aborts the shot without counting it.
            state_d = no_wire_q ? S_IDLE : S_WIRE_PULSE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_WIRE_PULSE: begin
          if (cnt_q == WP_LAST) begin
            state_d = S_TRIG_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_TRIG_WAIT: begin
          if (trig_rise) begin
            state_d = S_DET_BUSY;
            cnt_d   = '0;
            stuck_d = fault_detector_stuck;
          end
        end
        S_DET_BUSY: begin
          if (stuck_q) begin
            // Stuck detector: leave only when the trigger is released.
            // The counter saturates at its terminal count.
            if (!output_trigger) begin
              state_d      = S_IDLE;
              cnt_d        = '0;
              shot_count_d = shot_count_q + 16'h0001;
            end else if (cnt_q != DB_LAST) begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else if (cnt_q == DB_LAST) begin
            state_d = S_DET_READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_DET_READY: begin
          if (!output_trigger) begin
            state_d      = S_IDLE;
            cnt_d        = '0;
            shot_count_d = shot_count_q + 16'h0001;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase

      // A protocol error in the same cycle as an accepted start wins.
      if (err_set) begin
        error_d = 1'b1;
      end else if (err_clr) begin
        error_d = 1'b0;
      end
    end
  end

  // Output decode from the next state so the registered outputs line up
  // with the state they describe.
  always_comb begin
    fg_d    = (state_d == S_ARMED);
    wire_d  = (state_d == S_WIRE_PULSE);
    ready_d = (state_d == S_DET_READY);
    busy_d  = (state_d != S_IDLE);
  end

  assign fg_signal      = fg_q;
  assign wire_signal    = wire_q;
  assign detector_ready = ready_q;
  assign busy           = busy_q;
  assign shot_count     = shot_count_q;
  assign error          = error_q;

endmodule

// File: tb/tb_setup_responder.sv
// tb/tb_setup_responder.sv - scoreboard bench for setup_responder
module tb_setup_responder;

  localparam int FG = 10;
  localparam int WD = 5;
  localparam int WP = 2;
  localparam int DB = 3;

  // Output vector layout: {fg, wire, ready, busy, error, shot_count[15:0]}
  localparam logic [20:0] M_FG   = 21'h100000;
  localparam logic [20:0] M_WIRE = 21'h080000;
  localparam logic [20:0] M_RDY  = 21'h040000;
  localparam logic [20:0] M_BUSY = 21'h020000;
  localparam logic [20:0] M_ERR  = 21'h010000;
  localparam logic [20:0] M_SHOT = 21'h00FFFF;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b1;
  logic start_signal = 1'b0;
  logic detonation_signal = 1'b0;
  logic output_trigger = 1'b0;
  logic fault_no_wire = 1'b0;
  logic fault_detector_stuck = 1'b0;
  logic fg_signal, wire_signal, detector_ready, busy, error;
  logic [15:0] shot_count;

  setup_responder #(
    .FG_CHARGE_CYCLES    (FG),
    .WIRE_DELAY_CYCLES   (WD),
    .WIRE_PULSE_CYCLES   (WP),
    .DETECTOR_BUSY_CYCLES(DB),
    .CNT_W               (32)
  ) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .enable              (enable),
    .start_signal        (start_signal),
    .detonation_signal   (detonation_signal),
    .output_trigger      (output_trigger),
    .fault_no_wire       (fault_no_wire),
    .fault_detector_stuck(fault_detector_stuck),
    .fg_signal           (fg_signal),
    .wire_signal         (wire_signal),
    .detector_ready      (detector_ready),
    .busy                (busy),
    .shot_count          (shot_count),
    .error               (error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    int          c;
    logic [20:0] m;
    logic [20:0] v;
  } ev_t;

  ev_t         evq[$];
  logic [20:0] mexp = '0;
  logic [20:0] prev = '0;
  logic [15:0] m_shots = '0;
  logic [20:0] dout;

  assign dout = {fg_signal, wire_signal, detector_ready, busy, error, shot_count};

  // Expected output change visible after clock edge c, kept sorted by edge.
  function automatic void expect_at(int c, logic [20:0] m, logic [20:0] v);
    ev_t e;
    int  i;
    e.c = c;
    e.m = m;
    e.v = v & m;
    i = evq.size();
    while (i > 0 && evq[i-1].c > c) i--;
    evq.insert(i, e);
  endfunction

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: whenever the outputs move or an expected change falls due,
  // retire the due expectations and compare.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev = '0;
      mexp = '0;
    end else if (dout !== prev || (evq.size() > 0 && evq[0].c <= cyc)) begin
      while (evq.size() > 0 && evq[0].c <= cyc) begin
        ev_t e;
        e = evq.pop_front();
        mexp = (mexp & ~e.m) | e.v;
      end
      check("outputs", dout, mexp);
      prev = dout;
    end
  end

  // Wait until the next sampling edge is edge e (call from a negedge).
  task automatic goto_edge(input int e);
    while (cyc + 1 < e) @(negedge clock);
  endtask

  // inj: 0 none, 1 detonation in CHARGE, 2 start in ARMED, 3 trigger in CHARGE
  task automatic do_shot(input bit nowire, input bit stuck, input int gap,
                         input int tdly, input int hold, input int inj);
    int s, d, t, f, e;
    @(negedge clock);
    start_signal = 1'b1;
    s = cyc + 1;
    expect_at(s, M_BUSY | M_ERR, M_BUSY);
    expect_at(s + FG, M_FG, M_FG);
    @(negedge clock);
    start_signal = 1'b0;
    if (inj == 1 || inj == 3) begin
      e = s + 1 + int'($urandom_range(0, FG - 3));
      goto_edge(e);
      if (inj == 1) detonation_signal = 1'b1;
      else output_trigger = 1'b1;
      expect_at(e, M_ERR, M_ERR);
      @(negedge clock);
      detonation_signal = 1'b0;
      output_trigger = 1'b0;
    end
    if (inj == 2) begin
      if (gap < 3) gap = 3;
      e = s + FG + 1;
      goto_edge(e);
      start_signal = 1'b1;
      expect_at(e, M_ERR, M_ERR);
      @(negedge clock);
      start_signal = 1'b0;
    end
    d = s + FG + gap;
    goto_edge(d);
    detonation_signal = 1'b1;
    fault_no_wire = nowire;
    expect_at(d, M_FG, '0);
    if (nowire) begin
      expect_at(d + WD, M_BUSY, '0);
      @(negedge clock);
      detonation_signal = 1'b0;
      fault_no_wire = 1'b0;
      goto_edge(d + WD + 1);
      return;
    end
    expect_at(d + WD, M_WIRE, M_WIRE);
    expect_at(d + WD + WP, M_WIRE, '0);
    @(negedge clock);
    detonation_signal = 1'b0;
    fault_no_wire = 1'b0;
    t = d + WD + WP + tdly;
    goto_edge(t);
    output_trigger = 1'b1;
    fault_detector_stuck = stuck;
    if (stuck) begin
      f = t + hold;
    end else begin
      expect_at(t + DB, M_RDY, M_RDY);
      f = t + DB + hold;
    end
    m_shots = m_shots + 16'h0001;
    expect_at(f, M_RDY | M_BUSY | M_SHOT, {5'b0, m_shots});
    @(negedge clock);
    fault_detector_stuck = 1'b0;
    goto_edge(f);
    output_trigger = 1'b0;
    goto_edge(f + 1);
  endtask

  task automatic idle_error(input bit use_det);
    int e;
    @(negedge clock);
    if (use_det) detonation_signal = 1'b1;
    else output_trigger = 1'b1;
    e = cyc + 1;
    expect_at(e, M_ERR, M_ERR);
    @(negedge clock);
    detonation_signal = 1'b0;
    output_trigger = 1'b0;
  endtask

  task automatic abort_shot();
    int s, x;
    @(negedge clock);
    start_signal = 1'b1;
    s = cyc + 1;
    expect_at(s, M_BUSY | M_ERR, M_BUSY);
    @(negedge clock);
    start_signal = 1'b0;
    x = s + 1 + int'($urandom_range(0, FG - 2));
    goto_edge(x);
    enable = 1'b0;
    expect_at(x, M_BUSY, '0);
    @(negedge clock);
    enable = 1'b1;
  endtask

  task automatic reset_mid_pulse();
    int s, d;
    @(negedge clock);
    start_signal = 1'b1;
    s = cyc + 1;
    expect_at(s, M_BUSY | M_ERR, M_BUSY);
    expect_at(s + FG, M_FG, M_FG);
    @(negedge clock);
    start_signal = 1'b0;
    d = s + FG + 1;
    goto_edge(d);
    detonation_signal = 1'b1;
    expect_at(d, M_FG, '0);
    expect_at(d + WD, M_WIRE, M_WIRE);
    @(negedge clock);
    detonation_signal = 1'b0;
    goto_edge(d + WD + 1);
    @(posedge clock);
    #2;
    evq.delete();
    m_shots = '0;
    reset_n = 1'b0;
    #1;
    check("async_reset", dout, '0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_reset", dout, '0);
  endtask

  task automatic preload_wrap();
    @(posedge clock);
    #2;
    expect_at(cyc, M_SHOT, 21'h00FFFF);
    m_shots = 16'hFFFF;
    force dut.shot_count_q = 16'hFFFF;
    @(posedge clock);
    #2;
    release dut.shot_count_q;
    @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required to finish", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_state", dout, '0);
    reset_n = 1'b1;
    @(negedge clock);

    do_shot(1'b0, 1'b0, 2, 1, 6, 0);
    do_shot(1'b1, 1'b0, 2, 1, 1, 0);
    do_shot(1'b0, 1'b1, 2, 1, 5, 0);
    idle_error(1'b1);
    do_shot(1'b0, 1'b0, 1, 1, 1, 1);
    idle_error(1'b0);
    do_shot(1'b0, 1'b0, 3, 2, 2, 2);
    do_shot(1'b0, 1'b1, 1, 3, 1, 3);

    for (int i = 0; i < 30; i++) begin
      k = int'($urandom_range(0, 9));
      if (k == 0) idle_error(1'($urandom_range(0, 1)));
      else if (k == 1) abort_shot();
      else do_shot($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   int'($urandom_range(1, 5)), int'($urandom_range(1, 4)),
                   int'($urandom_range(1, 6)), int'($urandom_range(0, 3)));
    end

    reset_mid_pulse();
    do_shot(1'b0, 1'b0, 1, 1, 2, 0);

    preload_wrap();
    do_shot(1'b0, 1'b0, 2, 1, 2, 0);
    abort_shot();
    do_shot(1'b0, 1'b0, 1, 2, 1, 0);

    for (int i = 0; i < 100 && evq.size() > 0; i++) @(negedge clock);
    n_vec++;
    if (evq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected changes never seen, required 0", evq.size());
    end
    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
